// File: rtl/branch_tag_alloc_pkg.sv
// Shared branch-tag types and default sizing for the rename, ROB, RS and LSQ.
package rv32i_types;

    localparam int BR_TAG_DEPTH   = 8;
    localparam int BR_ALLOC_WIDTH = 2;
    localparam int BR_RES_PORTS   = 2;
    localparam int BR_TAG_W       = $clog2(BR_TAG_DEPTH);

    typedef logic [BR_TAG_W-1:0]     br_tag_t;
    typedef logic [BR_TAG_DEPTH-1:0] br_mask_t;

endpackage

// File: rtl/branch_tag_alloc_if.sv
// Dispatch-side allocation handshake and CDB resolution bundle for the tag allocator.
interface branch_tag_alloc_if #(
    parameter int TAG_DEPTH   = rv32i_types::BR_TAG_DEPTH,
    parameter int ALLOC_WIDTH = rv32i_types::BR_ALLOC_WIDTH,
    parameter int RES_PORTS   = rv32i_types::BR_RES_PORTS
);
    localparam int TW = $clog2(TAG_DEPTH);

    logic [ALLOC_WIDTH-1:0]                alloc_req;
    logic [ALLOC_WIDTH-1:0]                alloc_gnt;
    logic [ALLOC_WIDTH-1:0][TW-1:0]        alloc_tag;
    logic [ALLOC_WIDTH-1:0][TAG_DEPTH-1:0] alloc_dep;
    logic                                  alloc_stall;
    logic [RES_PORTS-1:0]                  res_valid;
    logic [RES_PORTS-1:0]                  res_mispred;
    logic [RES_PORTS-1:0][TW-1:0]          res_tag;

    // Front end / CDB side
    modport master (
        output alloc_req, res_valid, res_mispred, res_tag,
        input  alloc_gnt, alloc_tag, alloc_dep, alloc_stall
    );

    // Allocator side
    modport slave (
        input  alloc_req, res_valid, res_mispred, res_tag,
        output alloc_gnt, alloc_tag, alloc_dep, alloc_stall
    );

endinterface

// File: rtl/branch_tag_alloc_tag_pick.sv
// First-N-free selector: pick_o[k] is the k-th lowest set bit of free_i (one-hot).
module tag_pick #(
    parameter int DEPTH = 8,
    parameter int N     = 2
) (
    input  logic [DEPTH-1:0]        free_i,
    output logic [N-1:0][DEPTH-1:0] pick_o,
    output logic [N-1:0]            vld_o
);

    logic [DEPTH-1:0] avail;

    // Peel off the lowest remaining free bit once per lane
    always_comb begin
        avail  = free_i;
        pick_o = '0;
        vld_o  = '0;
        for (int k = 0; k < N; k++) begin
            pick_o[k] = avail & (~avail + DEPTH'(1));
            vld_o[k]  = |avail;
            avail     = avail & ~pick_o[k];
        end
    end

endmodule

// File: rtl/branch_tag_alloc.sv
// Branch tag allocator: hands out in-flight branch tags in program order, tracks
// which older branches each tag depends on, and turns CDB resolutions into
// kill/clear masks for the rest of the core.
module branch_tag_alloc
    import rv32i_types::*;
#(
    parameter int TAG_DEPTH   = BR_TAG_DEPTH,
    parameter int ALLOC_WIDTH = BR_ALLOC_WIDTH,
    parameter int RES_PORTS   = BR_RES_PORTS
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_tag_alloc_if.slave    bus,
    output logic [TAG_DEPTH-1:0] live_mask,
    output logic [TAG_DEPTH-1:0] kill_mask,
    output logic [TAG_DEPTH-1:0] clear_mask
);

    localparam int TW = $clog2(TAG_DEPTH);
    localparam int IW = (ALLOC_WIDTH > 1) ? $clog2(ALLOC_WIDTH + 1) : 1;

    logic [TAG_DEPTH-1:0]                  live_q, live_d;
    logic [TAG_DEPTH-1:0][TAG_DEPTH-1:0]   dep_q, dep_d;
    logic [ALLOC_WIDTH-1:0][TAG_DEPTH-1:0] pick;
    logic [ALLOC_WIDTH-1:0]                pick_vld;
    logic [TAG_DEPTH-1:0]                  gnt_mask;
    logic [TAG_DEPTH-1:0]                  clr_raw;
    logic [TAG_DEPTH-1:0]                  col_clr;
    logic                                  any_mispred;
    logic [IW-1:0]                         idx;
    logic                                  blocked;

    function automatic logic [TW-1:0] onehot_to_idx(input logic [TAG_DEPTH-1:0] oh);
        logic [TW-1:0] r;
        r = '0;
        for (int i = 0; i < TAG_DEPTH; i++) begin
            if (oh[i]) r = TW'(i);
        end
        return r;
    endfunction

    // Only the registered live set is offered, so tags freed this cycle wait a cycle
    tag_pick #(
        .DEPTH (TAG_DEPTH),
        .N     (ALLOC_WIDTH)
    ) u_tag_pick (
        .free_i (~live_q),
        .pick_o (pick),
        .vld_o  (pick_vld)
    );

    // Resolution: build kill set from mispredicts (with dependents) and clear set from correct ones
    always_comb begin
        kill_mask   = '0;
        clr_raw     = '0;
        any_mispred = 1'b0;
        for (int p = 0; p < RES_PORTS; p++) begin
            if (bus.res_valid[p] && live_q[bus.res_tag[p]]) begin
                if (bus.res_mispred[p]) begin
                    any_mispred                = 1'b1;
                    kill_mask[bus.res_tag[p]]  = 1'b1;
                    for (int u = 0; u < TAG_DEPTH; u++) begin
                        if (live_q[u] && dep_q[u][bus.res_tag[p]]) kill_mask[u] = 1'b1;
                    end
                end else begin
                    clr_raw[bus.res_tag[p]] = 1'b1;
                end
            end
        end
        clear_mask = clr_raw & ~kill_mask;
    end

    // Allocation: in-order grants without holes, lane dependency = live set plus older same-cycle grants
    always_comb begin
        bus.alloc_gnt = '0;
        bus.alloc_tag = '0;
        bus.alloc_dep = '0;
        gnt_mask      = '0;
        idx           = '0;
        blocked       = 1'b0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            bus.alloc_dep[k] = live_q | gnt_mask;
            if (bus.alloc_req[k]) begin
                if (!blocked && !any_mispred && pick_vld[idx]) begin
                    bus.alloc_gnt[k] = 1'b1;
                    bus.alloc_tag[k] = onehot_to_idx(pick[idx]);
                    gnt_mask         = gnt_mask | pick[idx];
                    idx              = idx + 1'b1;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
        bus.alloc_stall = ~pick_vld[ALLOC_WIDTH-1];
    end

    // Next state: retire killed/cleared tags, scrub their columns, load rows of new grants
    always_comb begin
        col_clr = kill_mask | clear_mask;
        live_d  = (live_q & ~col_clr) | gnt_mask;
        for (int u = 0; u < TAG_DEPTH; u++) begin
            dep_d[u] = kill_mask[u] ? '0 : dep_q[u];
        end
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            if (bus.alloc_gnt[k]) dep_d[bus.alloc_tag[k]] = bus.alloc_dep[k];
        end
        for (int u = 0; u < TAG_DEPTH; u++) begin
            dep_d[u] = dep_d[u] & ~col_clr;
        end
    end

    // State registers; reset wins over any concurrent allocation or resolution
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q <= '0;
            dep_q  <= '0;
        end else begin
            live_q <= live_d;
            dep_q  <= dep_d;
        end
    end

    assign live_mask = live_q;

endmodule

// File: tb/tb_branch_tag_alloc.sv
// Directed table-driven bench for branch_tag_alloc (default sizing: 8 tags, 2 lanes, 2 ports).
module tb_branch_tag_alloc;
    import rv32i_types::*;

    logic       clk;
    logic       rst;
    logic [7:0] live_mask, kill_mask, clear_mask;

    branch_tag_alloc_if #(.TAG_DEPTH(8), .ALLOC_WIDTH(2), .RES_PORTS(2)) bus ();

    branch_tag_alloc #(.TAG_DEPTH(8), .ALLOC_WIDTH(2), .RES_PORTS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .live_mask  (live_mask),
        .kill_mask  (kill_mask),
        .clear_mask (clear_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [1:0] rv;
        logic [1:0] rm;
        logic [2:0] rt0;
        logic [2:0] rt1;
        logic       chk;
        logic [1:0] gnt;
        logic [2:0] t0;
        logic [2:0] t1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       stall;
        logic [7:0] kill;
        logic [7:0] clr;
        logic [7:0] live;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   cur      = 0;

    task automatic add(input logic r, input logic [1:0] req, input logic [1:0] rv,
                       input logic [1:0] rm, input logic [2:0] rt0, input logic [2:0] rt1,
                       input logic chk, input logic [1:0] gnt, input logic [2:0] t0,
                       input logic [2:0] t1, input logic [7:0] d0, input logic [7:0] d1,
                       input logic stall, input logic [7:0] kill, input logic [7:0] clr,
                       input logic [7:0] live);
        vec_t v;
        v.rst = r; v.req = req; v.rv = rv; v.rm = rm; v.rt0 = rt0; v.rt1 = rt1;
        v.chk = chk; v.gnt = gnt; v.t0 = t0; v.t1 = t1; v.d0 = d0; v.d1 = d1;
        v.stall = stall; v.kill = kill; v.clr = clr; v.live = live;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", nm, cur, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] req, input logic [1:0] rv,
                         input logic [1:0] rm, input logic [2:0] rt0, input logic [2:0] rt1);
        rst                = r;
        bus.alloc_req      = req;
        bus.res_valid      = rv;
        bus.res_mispred    = rm;
        bus.res_tag[0]     = rt0;
        bus.res_tag[1]     = rt1;
    endtask

    initial begin
        drive(1'b1, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0);

        //   rst req  rv    rm    rt0 rt1 chk gnt   t0  t1  d0     d1     st  kill   clr    live
        add(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        add(0, 2'b11, 2'b00, 2'b00, 0, 0, 1, 2'b11, 0, 1, 8'h00, 8'h01, 0, 8'h00, 8'h00, 8'h00);
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h03);
        add(0, 2'b11, 2'b00, 2'b00, 0, 0, 1, 2'b11, 2, 3, 8'h03, 8'h07, 0, 8'h00, 8'h00, 8'h03);
        add(0, 2'b11, 2'b00, 2'b00, 0, 0, 1, 2'b11, 4, 5, 8'h0F, 8'h1F, 0, 8'h00, 8'h00, 8'h0F);
        add(0, 2'b11, 2'b00, 2'b00, 0, 0, 1, 2'b11, 6, 7, 8'h3F, 8'h7F, 0, 8'h00, 8'h00, 8'h3F);
        add(0, 2'b11, 2'b00, 2'b00, 0, 0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 8'hFF);
        add(0, 2'b00, 2'b01, 2'b01, 2, 0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 1, 8'hFC, 8'h00, 8'hFF);
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h03);
        add(0, 2'b01, 2'b00, 2'b00, 0, 0, 1, 2'b01, 2, 0, 8'h03, 8'h00, 0, 8'h00, 8'h00, 8'h03);
        add(0, 2'b00, 2'b11, 2'b10, 0, 1, 1, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h06, 8'h01, 8'h07);
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        add(0, 2'b11, 2'b00, 2'b00, 0, 0, 1, 2'b11, 0, 1, 8'h00, 8'h01, 0, 8'h00, 8'h00, 8'h00);
        add(0, 2'b11, 2'b00, 2'b00, 0, 0, 1, 2'b11, 2, 3, 8'h03, 8'h07, 0, 8'h00, 8'h00, 8'h03);
        add(0, 2'b11, 2'b00, 2'b00, 0, 0, 1, 2'b11, 4, 5, 8'h0F, 8'h1F, 0, 8'h00, 8'h00, 8'h0F);
        add(0, 2'b11, 2'b00, 2'b00, 0, 0, 1, 2'b11, 6, 7, 8'h3F, 8'h7F, 0, 8'h00, 8'h00, 8'h3F);
        add(0, 2'b01, 2'b10, 2'b00, 0, 3, 1, 2'b00, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h08, 8'hFF);
        add(0, 2'b01, 2'b00, 2'b00, 0, 0, 1, 2'b01, 3, 0, 8'hF7, 8'h00, 1, 8'h00, 8'h00, 8'hF7);
        add(0, 2'b00, 2'b01, 2'b01, 6, 0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 1, 8'hC8, 8'h00, 8'hFF);
        add(0, 2'b11, 2'b01, 2'b01, 5, 0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h20, 8'h00, 8'h37);
        add(0, 2'b00, 2'b11, 2'b01, 3, 7, 1, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h17);
        add(0, 2'b11, 2'b00, 2'b00, 0, 0, 1, 2'b11, 3, 5, 8'h17, 8'h1F, 0, 8'h00, 8'h00, 8'h17);
        add(1, 2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00);

        foreach (vecs[i]) begin
            @(negedge clk);
            cur = i;
            drive(vecs[i].rst, vecs[i].req, vecs[i].rv, vecs[i].rm, vecs[i].rt0, vecs[i].rt1);
            #1;
            if (vecs[i].chk) begin
                check("gnt",   32'(bus.alloc_gnt),   32'(vecs[i].gnt));
                check("stall", 32'(bus.alloc_stall), 32'(vecs[i].stall));
                check("kill",  32'(kill_mask),       32'(vecs[i].kill));
                check("clear", 32'(clear_mask),      32'(vecs[i].clr));
                check("live",  32'(live_mask),       32'(vecs[i].live));
                if (vecs[i].gnt[0]) begin
                    check("tag0", 32'(bus.alloc_tag[0]), 32'(vecs[i].t0));
                    check("dep0", 32'(bus.alloc_dep[0]), 32'(vecs[i].d0));
                end
                if (vecs[i].gnt[1]) begin
                    check("tag1", 32'(bus.alloc_tag[1]), 32'(vecs[i].t1));
                    check("dep1", 32'(bus.alloc_dep[1]), 32'(vecs[i].d1));
                end
            end
        end

        // Younger lane requesting alone takes the lowest free tag
        cur = 100;
        @(negedge clk);
        drive(1'b0, 2'b10, 2'b00, 2'b00, 3'd0, 3'd0);
        #1;
        check("solo_gnt",  32'(bus.alloc_gnt),    32'h2);
        check("solo_tag1", 32'(bus.alloc_tag[1]), 32'h0);
        check("solo_dep1", 32'(bus.alloc_dep[1]), 32'h00);

        // Next cycle: tag 0 live, pair request gets tags 1 and 2 chained on it
        cur = 101;
        @(negedge clk);
        drive(1'b0, 2'b11, 2'b00, 2'b00, 3'd0, 3'd0);
        #1;
        check("pair_live", 32'(live_mask),        32'h01);
        check("pair_gnt",  32'(bus.alloc_gnt),    32'h3);
        check("pair_tag0", 32'(bus.alloc_tag[0]), 32'h1);
        check("pair_tag1", 32'(bus.alloc_tag[1]), 32'h2);
        check("pair_dep0", 32'(bus.alloc_dep[0]), 32'h01);
        check("pair_dep1", 32'(bus.alloc_dep[1]), 32'h03);

        cur = 102;
        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0);
        #1;
        check("pair_live_next", 32'(live_mask), 32'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
